avalon_burst_master: RTL and testbench

Avalon-MM burst master that sits directly upstream of the Avalon BRAM controller and drives its slave interface. It accepts a transfer command (direction, byte base address, length in words) and splits it into bursts of at most MAX_BURST words. Write data comes in from a ready/valid stream. Read data leaves on a valid-only stream. It is the traffic source for controller bring-up and benchmarking on the FPGA.

---
 rtl/avalon_burst_master.sv | 159 +++++++++++++++
 tb/tb_avalon_burst_master.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_burst_master.sv
// Avalon-MM burst master: splits a (direction, byte address, word length) command into
// bursts of at most MAX_BURST words, fed from a write stream or draining into a read stream.
module avalon_burst_master #(
    parameter int DATA_BYTES   = 4,
    parameter int BURSTCOUNT_W = 6,
    parameter int ADDR_W       = 32,
    parameter int LEN_W        = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_W-1:0]       cmd_address,
    input  logic [LEN_W-1:0]        cmd_length,
    input  logic [8*DATA_BYTES-1:0] wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [8*DATA_BYTES-1:0] rd_data,
    output logic                    rd_valid,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_W-1:0]       address,
    output logic [DATA_BYTES-1:0]   byteenable,
    output logic                    read,
    output logic                    write,
    output logic [8*DATA_BYTES-1:0] writedata,
    output logic [BURSTCOUNT_W-1:0] burstcount,
    input  logic [8*DATA_BYTES-1:0] readdata,
    input  logic                    readdatavalid,
    input  logic                    waitrequest
);

    localparam int MAX_BURST = 2**(BURSTCOUNT_W-1);

    typedef enum logic [2:0] {IDLE, WR_BURST, RD_CMD, RD_DATA, DONE} state_t;

    state_t                  state;
    logic [LEN_W-1:0]        rem;       // words left once the current burst completes
    logic [BURSTCOUNT_W-1:0] beat_cnt;
    logic                    wr_beat;
    logic                    last_beat;

    function automatic logic [BURSTCOUNT_W-1:0] burst_len(input logic [LEN_W-1:0] words);
        if (words >= LEN_W'(MAX_BURST))
            return BURSTCOUNT_W'(MAX_BURST);
        return BURSTCOUNT_W'(words);
    endfunction

    function automatic logic [ADDR_W-1:0] next_base(input logic [ADDR_W-1:0]       base,
                                                    input logic [BURSTCOUNT_W-1:0] words);
        return base + ADDR_W'(words) * ADDR_W'(DATA_BYTES);
    endfunction

    // Write side is a straight pass-through of the stream; only the burst header is registered.
    assign write      = (state == WR_BURST) && wr_valid;
    assign wr_ready   = (state == WR_BURST) && !waitrequest;
    assign writedata  = wr_data;
    assign byteenable = '1;
    assign wr_beat    = write && !waitrequest;
    assign last_beat  = (beat_cnt == burstcount - BURSTCOUNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            read       <= 1'b0;
            address    <= '0;
            burstcount <= '0;
            rem        <= '0;
            beat_cnt   <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        address    <= cmd_address;
                        beat_cnt   <= '0;
                        burstcount <= burst_len(cmd_length);
                        rem        <= cmd_length - LEN_W'(burst_len(cmd_length));
                        if (cmd_length == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (cmd_write) begin
                            state <= WR_BURST;
                        end else begin
                            state <= RD_CMD;
                            read  <= 1'b1;
                        end
                    end
                end

                WR_BURST: begin
                    if (wr_beat) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            address  <= next_base(address, burstcount);
                            if (rem != '0) begin
                                burstcount <= burst_len(rem);
                                rem        <= rem - LEN_W'(burst_len(rem));
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + BURSTCOUNT_W'(1);
                        end
                    end
                end

                RD_CMD: begin
                    if (!waitrequest) begin
                        read  <= 1'b0;
                        state <= RD_DATA;
                    end
                end

                // Next read request waits until every beat of this burst has returned.
                RD_DATA: begin
                    if (readdatavalid) begin
                        rd_data  <= readdata;
                        rd_valid <= 1'b1;
                        if (last_beat) begin
                            beat_cnt <= '0;
                            address  <= next_base(address, burstcount);
                            if (rem != '0) begin
                                burstcount <= burst_len(rem);
                                rem        <= rem - LEN_W'(burst_len(rem));
                                read       <= 1'b1;
                                state      <= RD_CMD;
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + BURSTCOUNT_W'(1);
                        end
                    end
                end

                DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_burst_master.sv
// Bench for avalon_burst_master: Avalon slave memory model, command-level reference model,
// table-driven command vectors, hand-built stall/abort sequences and randomized commands.
module tb_avalon_burst_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_address;
    logic [15:0] cmd_length;
    logic [31:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, busy, done;
    logic [31:0] address;
    logic [3:0]  byteenable;
    logic        read, write;
    logic [31:0] writedata;
    logic [5:0]  burstcount;
    logic [31:0] readdata;
    logic        readdatavalid, waitrequest;

    always #5 clk = ~clk;

    avalon_burst_master #(
        .DATA_BYTES(4), .BURSTCOUNT_W(6), .ADDR_W(32), .LEN_W(16)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_length(cmd_length),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
        .address(address), .byteenable(byteenable), .read(read), .write(write),
        .writedata(writedata), .burstcount(burstcount), .readdata(readdata),
        .readdatavalid(readdatavalid), .waitrequest(waitrequest)
    );

    typedef struct { logic [31:0] a; int bc; } burst_t;
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        int          len;
        int          nb;
        int          last_bc;
        logic [31:0] last_addr;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] wq[$];
    logic [31:0] pending[$];
    logic [31:0] exp_rd[$];
    burst_t      exp_bursts[$];
    logic [31:0] smem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];

    int ret_wait = 0;
    bit manual = 1'b1, man_wv = 1'b1, man_wait = 1'b0, man_rdv = 1'b0;
    int p_wait = 0, p_wv = 100, p_rdv = 100;

    int          wbeat = 0;
    logic [31:0] wb_addr = '0;
    int          wb_bc = 0;
    int          bursts_seen = 0, rw_seen = 0, done_cnt = 0, last_beat_cyc = 0;
    int          last_bc = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] drv_a;

    vec_t vecs[8];
    bit   pat_wv[10]   = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
    bit   pat_wait[10] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] fill(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic new_burst(input logic [31:0] a, input int bc);
        burst_t e;
        bursts_seen++;
        last_addr = a;
        last_bc   = bc;
        wb_addr   = a;
        wb_bc     = bc;
        if (exp_bursts.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL burst_extra: actual burst at %0h count %0d, required no burst", a, bc);
        end else begin
            e = exp_bursts.pop_front();
            chk("burst_addr", a, e.a);
            chk("burst_count", bc, e.bc);
        end
    endtask

    // Slave side and stream sources, driven 1ns after each rising edge.
    always @(posedge clk) begin
        #1;
        if (manual) begin
            waitrequest = man_wait;
            wr_valid    = man_wv && (wq.size() > 0);
        end else begin
            waitrequest = ($urandom_range(0, 99) < p_wait);
            wr_valid    = ($urandom_range(0, 99) < p_wv) && (wq.size() > 0);
        end
        wr_data       = (wq.size() > 0) ? wq[0] : 32'h0;
        readdatavalid = 1'b0;
        readdata      = 32'h0;
        if (ret_wait > 0) ret_wait--;
        if (ret_wait == 0 && pending.size() > 0 && $urandom_range(0, 99) < p_rdv) begin
            drv_a         = pending.pop_front();
            readdatavalid = 1'b1;
            readdata      = smem.exists(drv_a) ? smem[drv_a] : fill(drv_a);
        end else if (man_rdv) begin
            readdatavalid = 1'b1;
            readdata      = 32'hDEAD_BEEF;
            man_rdv       = 1'b0;
        end
    end

    // Bus monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (read || write) begin
                rw_seen++;
                chk("rw_exclusive", {read, write} == 2'b11, 0);
                chk("byteenable", byteenable, 4'hF);
            end
            if (write && !waitrequest) begin
                if (wbeat == 0) begin
                    new_burst(address, int'(burstcount));
                end else begin
                    chk("wr_addr_stable", address, wb_addr);
                    chk("wr_bc_stable", burstcount, wb_bc);
                end
                smem[wb_addr + 32'(4 * wbeat)] = writedata;
                wbeat++;
                if (wbeat >= wb_bc) wbeat = 0;
                last_beat_cyc = cyc;
            end
            if (wr_valid && wr_ready && wq.size() > 0) void'(wq.pop_front());
            if (read) chk("rd_outstanding", pending.size(), 0);
            if (read && !waitrequest) begin
                new_burst(address, int'(burstcount));
                for (int i = 0; i < int'(burstcount); i++) pending.push_back(address + 32'(4 * i));
                ret_wait = 2;
            end
            if (readdatavalid) last_beat_cyc = cyc;
            if (rd_valid) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_extra: actual rd_valid with data %0h, required none", rd_data);
                end else begin
                    chk("rd_data", rd_data, exp_rd.pop_front());
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic run_cmd(input bit wr, input logic [31:0] addr, input int len);
        logic [31:0] a;
        logic [31:0] d;
        int rem, b, g, acc_cyc, done_cyc;
        bit accepted, got_done;
        exp_bursts.delete();
        exp_rd.delete();
        a   = addr;
        rem = len;
        while (rem > 0) begin
            b = (rem > 32) ? 32 : rem;
            exp_bursts.push_back(burst_t'{a, b});
            a   = a + 32'(4 * b);
            rem = rem - b;
        end
        for (int i = 0; i < len; i++) begin
            a = addr + 32'(4 * i);
            if (wr) begin
                d = $urandom;
                ref_mem[a] = d;
                wq.push_back(d);
            end else begin
                exp_rd.push_back(ref_mem.exists(a) ? ref_mem[a] : fill(a));
            end
        end
        bursts_seen = 0; last_bc = 0; last_addr = '0; rw_seen = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_address = addr; cmd_length = 16'(len);
        accepted = 0; acc_cyc = 0; g = 0;
        while (!accepted && g < 50) begin
            @(negedge clk);
            if (cmd_ready) begin accepted = 1; acc_cyc = cyc; end
            g++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("cmd_accepted", accepted, 1);
        got_done = 0; done_cyc = 0; g = 0;
        while (!got_done && g < 5000) begin
            @(negedge clk);
            if (done) begin got_done = 1; done_cyc = cyc; end
            g++;
        end
        chk("done_seen", got_done, 1);
        if (len == 0) chk("done_after_accept", done_cyc - acc_cyc, 1);
        else          chk("done_after_last_beat", done_cyc - last_beat_cyc, 1);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("bursts_left", exp_bursts.size(), 0);
        chk("rd_left", exp_rd.size(), 0);
        chk("wq_left", wq.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        int g, dc0;
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_length = '0;
        wr_valid = 1'b0; wr_data = '0; waitrequest = 1'b0;
        readdatavalid = 1'b0; readdata = '0;

        vecs[0] = '{1'b1, 32'h0000_0100, 70, 3, 6, 32'h0000_0200};
        vecs[1] = '{1'b1, 32'h0000_0100,  8, 1, 8, 32'h0000_0100};
        vecs[2] = '{1'b0, 32'h0000_0100, 70, 3, 6, 32'h0000_0200};
        vecs[3] = '{1'b1, 32'h0000_1000, 33, 2, 1, 32'h0000_1080};
        vecs[4] = '{1'b0, 32'h0000_1000, 33, 2, 1, 32'h0000_1080};
        vecs[5] = '{1'b1, 32'hFFFF_FFF0,  8, 1, 8, 32'hFFFF_FFF0};
        vecs[6] = '{1'b0, 32'hFFFF_FFF0,  8, 1, 8, 32'hFFFF_FFF0};
        vecs[7] = '{1'b1, 32'h0000_0300,  0, 0, 0, 32'h0000_0000};

        repeat (3) @(negedge clk);
        chk("rst_read", read, 0);
        chk("rst_write", write, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_address", address, 0);
        chk("rst_burstcount", burstcount, 0);
        chk("rst_rd_data", rd_data, 0);
        reset = 1'b0;
        manual = 1'b0; p_wait = 0; p_wv = 100; p_rdv = 100;

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].len);
            chk("vec_nbursts", bursts_seen, vecs[i].nb);
            chk("vec_last_bc", last_bc, vecs[i].last_bc);
            chk("vec_last_addr", last_addr, vecs[i].last_addr);
            chk("vec_bus_activity", rw_seen != 0, vecs[i].len != 0);
        end

        // Write of 5 with stream gaps and a 3-cycle slave stall inside one burst.
        manual = 1'b1; man_wv = pat_wv[0]; man_wait = pat_wait[0];
        fork
            run_cmd(1'b1, 32'h0000_0400, 5);
            begin
                g = 0;
                do begin @(negedge clk); g++; end while (!busy && g < 20);
                for (int c = 0; c < 10; c++) begin
                    if (c > 0) @(negedge clk);
                    chk("stall_wr_ready", wr_ready, !pat_wait[c]);
                    chk("stall_write", write, pat_wv[c]);
                    chk("stall_address", address, 32'h0000_0400);
                    chk("stall_burstcount", burstcount, 5);
                    man_wv   = (c < 9) ? pat_wv[c+1] : 1'b1;
                    man_wait = (c < 9) ? pat_wait[c+1] : 1'b0;
                end
            end
        join
        manual = 1'b0;

        // Stray readdatavalid while idle must not reach the read stream.
        @(negedge clk);
        man_rdv = 1'b1;
        repeat (2) @(negedge clk);
        chk("stray_rdv_valid", rd_valid, 0);
        chk("stray_rdv_data", rd_data == 32'hDEAD_BEEF, 0);

        // Reset during the second burst of a 40-word write.
        p_wait = 0; p_wv = 100;
        exp_bursts.delete();
        exp_bursts.push_back(burst_t'{32'h0002_0000, 32});
        exp_bursts.push_back(burst_t'{32'h0002_0080, 8});
        for (int i = 0; i < 40; i++) wq.push_back($urandom);
        bursts_seen = 0;
        dc0 = done_cnt;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 32'h0002_0000; cmd_length = 16'd40;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        g = 0;
        while (bursts_seen < 2 && g < 500) begin @(negedge clk); g++; end
        chk("abort_second_burst", bursts_seen, 2);
        @(negedge clk);
        chk("abort_write_before", write, 1);
        #2 reset = 1'b1;
        #1;
        chk("abort_write_async", write, 0);
        chk("abort_busy_async", busy, 0);
        chk("abort_read_async", read, 0);
        wq.delete(); pending.delete(); exp_bursts.delete(); wbeat = 0; ret_wait = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_no_done", done_cnt, dc0);
        run_cmd(1'b0, 32'h0000_0100, 8);

        // Randomized commands against the reference model.
        for (int n = 0; n < 14; n++) begin
            p_wait = $urandom_range(0, 50);
            p_wv   = $urandom_range(40, 100);
            p_rdv  = $urandom_range(40, 100);
            run_cmd(1'($urandom_range(0, 1)), 32'h0000_8000 + 32'(4 * $urandom_range(0, 63)),
                    $urandom_range(0, 80));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
